// File: rtl/i2c_target_controller_if.sv
// Signal bundle between an I2C target endpoint and the logic around it:
// line levels, the open-drain SDA pull-down, read/write data words and
// transaction status pulses, plus the FSM state for observation.
`timescale 1ns/1ps
interface i2c_target_controller_if;
   logic        scl_i;
   logic        sda_i;
   logic        sda_oe;
   logic [31:0] tx_word;
   logic [31:0] rx_word;
   logic [2:0]  rx_count;
   logic        rx_valid;
   logic        done;
   logic        busy;
   logic [2:0]  state_dbg;

   modport master (
      output scl_i, sda_i, tx_word,
      input  sda_oe, rx_word, rx_count, rx_valid, done, busy, state_dbg
   );

   modport slave (
      input  scl_i, sda_i, tx_word,
      output sda_oe, rx_word, rx_count, rx_valid, done, busy, state_dbg
   );
endinterface

// File: rtl/i2c_target_controller.sv
// I2C target endpoint. SCL/SDA are oversampled on clk; START/STOP are
// detected from the synchronised lines. Acknowledges TARGET_ADDR, packs up
// to 4 write bytes into rx_word (first byte -> [7:0]) and serves up to 4
// read bytes from tx_word (byte 0 first, then 8'hFF beyond the 4th).
`timescale 1ns/1ps
module i2c_target_controller #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input logic                      clk,
   input logic                      nrst,
   i2c_target_controller_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_s, sda_s, scl_d, sda_d;
   logic scl_rise, scl_fall, bus_start, bus_stop;
   logic [7:0] new_byte;

   state_t      state, state_n;
   logic [2:0]  bit_cnt, bit_cnt_n;
   logic [6:0]  shreg, shreg_n;
   logic [23:0] tx_buf, tx_buf_n;
   logic        rw, rw_n;
   logic        ack_ok, ack_ok_n;
   logic        wr_open, wr_open_n;
   logic        rd_open, rd_open_n;
   logic        sda_oe_q, sda_oe_n;
   logic        busy_q, busy_n;
   logic [31:0] rx_word_q, rx_word_n;
   logic [2:0]  rx_count_q, rx_count_n;
   logic        rx_valid_q, rx_valid_n;
   logic        done_q, done_n;

   // Line synchronisers and edge-detect register, preset to the idle bus level
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign bus_start = scl_s & scl_d & sda_d & ~sda_s;
   assign bus_stop  = scl_s & scl_d & ~sda_d & sda_s;
   assign new_byte  = {shreg, sda_s};

   // State and datapath registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         tx_buf     <= '0;
         rw         <= 1'b0;
         ack_ok     <= 1'b0;
         wr_open    <= 1'b0;
         rd_open    <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         rx_word_q  <= '0;
         rx_count_q <= '0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         tx_buf     <= tx_buf_n;
         rw         <= rw_n;
         ack_ok     <= ack_ok_n;
         wr_open    <= wr_open_n;
         rd_open    <= rd_open_n;
         sda_oe_q   <= sda_oe_n;
         busy_q     <= busy_n;
         rx_word_q  <= rx_word_n;
         rx_count_q <= rx_count_n;
         rx_valid_q <= rx_valid_n;
         done_q     <= done_n;
      end
   end

   // Next-state logic; bus START/STOP override any bit activity.
   // The ACK states use sda_oe itself to tell the fall that begins the
   // ACK bit from the fall that ends it.
   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      tx_buf_n   = tx_buf;
      rw_n       = rw;
      ack_ok_n   = ack_ok;
      wr_open_n  = wr_open;
      rd_open_n  = rd_open;
      sda_oe_n   = sda_oe_q;
      busy_n     = busy_q;
      rx_word_n  = rx_word_q;
      rx_count_n = rx_count_q;
      rx_valid_n = 1'b0;
      done_n     = 1'b0;

      if (bus_stop) begin
         state_n    = IDLE;
         sda_oe_n   = 1'b0;
         busy_n     = 1'b0;
         rx_valid_n = wr_open && (rx_count_q != 3'd0);
         done_n     = rd_open;
         wr_open_n  = 1'b0;
         rd_open_n  = 1'b0;
      end else if (bus_start) begin
         state_n    = ADDR;
         bit_cnt_n  = '0;
         sda_oe_n   = 1'b0;
         ack_ok_n   = 1'b0;
         rx_valid_n = wr_open && (rx_count_q != 3'd0);
         done_n     = rd_open;
         wr_open_n  = 1'b0;
         rd_open_n  = 1'b0;
      end else begin
         case (state)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shreg_n   = new_byte[6:0];
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rw_n = sda_s;
                     if (new_byte[7:1] == TARGET_ADDR && new_byte[7:1] != 7'd0) begin
                        state_n = ADDR_ACK;
                        busy_n  = 1'b1;
                        if (!sda_s) begin
                           rx_count_n = '0;
                           wr_open_n  = 1'b1;
                        end else begin
                           rd_open_n  = 1'b1;
                        end
                     end else begin
                        state_n  = WAIT_STOP;
                        sda_oe_n = 1'b0;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_n = 1'b1;
                  end else if (!rw) begin
                     state_n   = WR;
                     sda_oe_n  = 1'b0;
                     bit_cnt_n = '0;
                  end else begin
                     state_n   = RD;
                     tx_buf_n  = bus.tx_word[31:8];
                     shreg_n   = bus.tx_word[6:0];
                     sda_oe_n  = ~bus.tx_word[7];
                     bit_cnt_n = '0;
                  end
               end
            end
            WR: begin
               if (scl_rise) begin
                  shreg_n   = new_byte[6:0];
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (!rx_count_q[2]) begin
                        rx_word_n[{rx_count_q[1:0], 3'b000} +: 8] = new_byte;
                        rx_count_n = rx_count_q + 3'd1;
                        state_n    = WR_ACK;
                     end else begin
                        state_n = WAIT_STOP;
                     end
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_n = 1'b1;
                  end else begin
                     sda_oe_n  = 1'b0;
                     state_n   = WR;
                     bit_cnt_n = '0;
                  end
               end
            end
            RD: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_oe_n = 1'b0;
                     state_n  = RD_ACK;
                     ack_ok_n = 1'b0;
                  end else begin
                     sda_oe_n  = ~shreg[6];
                     shreg_n   = {shreg[5:0], 1'b1};
                     bit_cnt_n = bit_cnt + 3'd1;
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s) state_n = WAIT_STOP;
                  else       ack_ok_n = 1'b1;
               end else if (scl_fall && ack_ok) begin
                  state_n   = RD;
                  tx_buf_n  = {8'hFF, tx_buf[23:8]};
                  shreg_n   = tx_buf[6:0];
                  sda_oe_n  = ~tx_buf[7];
                  bit_cnt_n = '0;
                  ack_ok_n  = 1'b0;
               end
            end
            WAIT_STOP: sda_oe_n = 1'b0;
            default:   state_n  = IDLE;
         endcase
      end
   end

   assign bus.sda_oe    = sda_oe_q;
   assign bus.rx_word   = rx_word_q;
   assign bus.rx_count  = rx_count_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.state_dbg = state;

endmodule
